// File: rtl/div_iterative_pkg.sv
// div_iterative_pkg: shared widths, iteration count and FSM encoding for the iterative divider
package div_iterative_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;
    localparam int CNT_W     = 6;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/div_iterative_step.sv
// div_step: one restoring-division step on an already shifted partial remainder.
//   r_sh  : 33-bit shifted remainder {R, next dividend bit}
//   d     : divisor magnitude
//   r_nx  : remainder after the trial subtraction (restored on borrow)
//   q_bit : quotient bit produced by this step
module div_step
    import div_iterative_pkg::*;
(
    input  logic [DIV_WIDTH:0]   r_sh,
    input  logic [DIV_WIDTH-1:0] d,
    output logic [DIV_WIDTH-1:0] r_nx,
    output logic                 q_bit
);
    logic [DIV_WIDTH-1:0] diff;
    logic                 c_out;
    sub32 u_sub (.a(r_sh[DIV_WIDTH-1:0]), .b(d), .diff(diff), .c_out(c_out));
    // A set bit 32 always covers a low-word borrow. The kept remainder is
    // below d, so it always fits in 32 bits and bit 32 never needs storing.
    assign q_bit = r_sh[DIV_WIDTH] | c_out;
    assign r_nx  = q_bit ? diff : r_sh[DIV_WIDTH-1:0];
endmodule

// File: rtl/div_iterative_sub32.sv
// sub32: 32-bit subtraction stage, diff = a + ~b + 1.
//   a, b  : operands
//   diff  : a - b (mod 2^32)
//   c_out : 1 when no borrow occurred (a >= b, unsigned)
module sub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        c_out
);
    assign {c_out, diff} = {1'b0, a} + {1'b0, ~b} + 33'd1;
endmodule

// File: rtl/div_iterative.sv
// div_iterative: multi-cycle signed 32-bit restoring divider.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   data_operandA  : dividend, sampled when ctrl_DIV=1
//   data_operandB  : divisor, sampled when ctrl_DIV=1
//   ctrl_DIV       : start pulse, restarts from any state
//   data_result    : quotient truncated toward zero, held until next completion
//   data_exception : divide-by-zero flag, held alongside data_result
//   data_resultRDY : one-cycle completion pulse
module div_iterative
    import div_iterative_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = DIV_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d, q_q, q_d, d_q, d_d, result_q, result_d;
    logic               sign_q, sign_d, dbz_q, dbz_d, exc_q, exc_d, rdy_q, rdy_d;
    logic [WIDTH-1:0]   neg_a, neg_b, neg_q, abs_a, abs_b, r_nx;
    logic               c_a, c_q, b_zero, q_bit, unused_c;

    sub32 u_neg_a (.a({WIDTH{1'b0}}), .b(data_operandA), .diff(neg_a), .c_out(c_a));
    // 0 - B only avoids a borrow when B is zero, so this carry is the divide-by-zero test
    sub32 u_neg_b (.a({WIDTH{1'b0}}), .b(data_operandB), .diff(neg_b), .c_out(b_zero));
    sub32 u_neg_q (.a({WIDTH{1'b0}}), .b(q_q), .diff(neg_q), .c_out(c_q));
    div_step u_step (.r_sh({r_q, q_q[WIDTH-1]}), .d(d_q), .r_nx(r_nx), .q_bit(q_bit));

    assign unused_c = c_a ^ c_q;
    assign abs_a    = data_operandA[WIDTH-1] ? neg_a : data_operandA;
    assign abs_b    = data_operandB[WIDTH-1] ? neg_b : data_operandB;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        sign_d   = sign_q;
        dbz_d    = dbz_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = (state_q == DONE);
        if (state_q == RUN) begin
            r_d     = r_nx;
            q_d     = {q_q[WIDTH-2:0], q_bit};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CNT_W'(ITER - 1)) ? DONE : RUN;
        end
        if (state_q == DONE) begin
            result_d = dbz_q ? '0 : (sign_q ? neg_q : q_q);
            exc_d    = dbz_q;
            state_d  = IDLE;
        end
        // A start overrides the step in progress; the DONE outputs above still commit
        if (ctrl_DIV) begin
            q_d     = abs_a;
            d_d     = abs_b;
            r_d     = '0;
            sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dbz_d   = b_zero;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            sign_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            sign_q   <= sign_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_div_iterative.sv
// tb_div_iterative: randomized and directed checks of div_iterative against an arithmetic model
module tb_div_iterative;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    int          checks = 0;
    int          errors = 0;

    div_iterative dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_DIV(ctrl_DIV),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {exception, quotient}: signed division truncating toward zero, done in 64 bits
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint q;
        if (b == 0) return {1'b1, 32'h0};
        q = longint'($signed(a)) / longint'($signed(b));
        return {1'b0, q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_check(input logic [31:0] a, input logic [31:0] b);
        int lat = 0;
        logic [32:0] e;
        e = ref_div(a, b);
        do begin
            tick();
            lat++;
        end while (!data_resultRDY && lat < 40);
        chk("latency", lat, 33);
        chk("result", data_result, e[31:0]);
        chk("exception", {31'b0, data_exception}, {31'b0, e[32]});
        tick();
        chk("rdy_one_cycle", {31'b0, data_resultRDY}, 32'd0);
        chk("result_hold", data_result, e[31:0]);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        wait_check(a, b);
    endtask

    task automatic expect_silence(input string tag, input int n);
        int pulses = 0;
        repeat (n) begin
            tick();
            if (data_resultRDY) pulses++;
        end
        chk(tag, pulses, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [32:0] e;
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_result", data_result, 32'h0);
        chk("reset_exc", {31'b0, data_exception}, 32'd0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        expect_silence("idle_no_rdy", 5);

        do_div(32'd100, 32'd7);
        do_div(-32'sd100, 32'd7);
        do_div(32'd100, -32'sd7);
        do_div(-32'sd100, -32'sd7);
        do_div(32'd7, 32'd0);
        do_div(32'd7, 32'd1);
        do_div(32'h80000000, 32'hFFFFFFFF);
        do_div(32'h80000000, 32'd1);
        do_div(32'd5, 32'd9);
        do_div(32'h7FFFFFFF, 32'h80000000);
        do_div(32'h80000000, 32'h80000000);

        // restart mid-run: only the second operation completes
        issue(32'd100, 32'd7);
        expect_silence("restart_no_rdy", 9);
        do_div(32'd81, 32'd9);

        // start in the DONE cycle: old result still pulses, new one follows
        issue(32'd1000, 32'd10);
        repeat (32) tick();
        issue(32'd45, -32'sd5);
        chk("done_restart_rdy", {31'b0, data_resultRDY}, 32'd1);
        chk("done_restart_old", data_result, 32'd100);
        wait_check(32'd45, -32'sd5);

        // reset during RUN
        issue(32'd100, 32'd7);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_silence("reset_run_no_rdy", 40);
        chk("reset_run_result", data_result, 32'h0);
        chk("reset_run_exc", {31'b0, data_exception}, 32'd0);
        do_div(32'd12, 32'd4);

        // reset and start together: reset wins
        reset = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        ctrl_DIV = 1'b1;
        tick();
        reset = 1'b0;
        ctrl_DIV = 1'b0;
        expect_silence("reset_wins_no_rdy", 40);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 40)) - 32'd20;
                2: b = 32'h0;
                default: b = a >> $urandom_range(1, 20);
            endcase
            if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
            do_div(a, b);
        end

        // back-to-back random restarts: only the final one reports
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        issue($urandom, $urandom);
        issue($urandom, $urandom);
        issue(a, b);
        e = ref_div(a, b);
        wait_check(a, b);
        chk("b2b_model", data_result, e[31:0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
